// File: rtl/note_rec_pkg.sv
// note_rec_pkg: shared note codes, byte markers, default depth and FSM states for the note recorder.
package note_rec_pkg;
    localparam logic [3:0] REST     = 4'd0;
    localparam logic [3:0] NOTE_C   = 4'd1;
    localparam logic [3:0] NOTE_CS  = 4'd2;
    localparam logic [3:0] NOTE_D   = 4'd3;
    localparam logic [3:0] NOTE_DS  = 4'd4;
    localparam logic [3:0] NOTE_E   = 4'd5;
    localparam logic [3:0] NOTE_F   = 4'd6;
    localparam logic [3:0] NOTE_FS  = 4'd7;
    localparam logic [3:0] NOTE_G   = 4'd8;
    localparam logic [3:0] NOTE_GS  = 4'd9;
    localparam logic [3:0] NOTE_A   = 4'd10;
    localparam logic [3:0] NOTE_AS  = 4'd11;
    localparam logic [3:0] NOTE_B   = 4'd12;
    localparam logic [7:0] END_MARK = 8'hFF;
    localparam logic [7:0] PAD      = 8'h00;
    localparam int DEPTH_DEF = 512;
    typedef enum logic [1:0] {IDLE, FILL, FLUSH} state_t;
    function automatic logic [3:0] clean_note(input logic [3:0] n);
        return (n > NOTE_B) ? REST : n;
    endfunction
endpackage

// File: rtl/note_rec_dpram.sv
// note_rec_dpram: 2*DEPTH x 8 RAM, one write port and one registered read port; address MSB selects the buffer.
module note_rec_dpram #(
    parameter int DEPTH = 512,
    parameter int AW = $clog2(2 * DEPTH)
) (
    input  logic          CLOCK_IO,
    input  logic          resetn,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem [2*DEPTH];
    always_ff @(posedge CLOCK_IO)
        if (we) mem[waddr] <= wdata;
    always_ff @(posedge CLOCK_IO or negedge resetn)
        if (!resetn) rdata <= '0;
        else rdata <= mem[raddr];
endmodule

// File: rtl/note_record_pingpong.sv
// note_record_pingpong: records note samples into two ping-pong sector buffers drained by an SD writer.
// Define NOTE_RLE_EN to store {run,note} run-length bytes instead of one raw byte per sample.
module note_record_pingpong import note_rec_pkg::*; #(
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = 16
) (
    input  logic             CLOCK_IO,
    input  logic             resetn,
    input  logic             rec_en,
    input  logic [3:0]       note_code,
    output logic             blk_valid,
    output logic             blk_sel,
    input  logic             blk_ack,
    input  logic [8:0]       rd_addr,
    output logic [7:0]       rd_data,
    output logic             overrun,
    output logic [8:0]       wr_ptr,
    output logic [CNT_W-1:0] blk_count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [8:0] LAST = 9'(DEPTH - 1);
    state_t state, state_n;
    logic [1:0] full, full_c, clr;
    logic [3:0] s;
    logic [7:0] wbyte, sample_byte;
    logic fill_sel, drain_sel, mark, tgt, emit, sample_emit, blocked, we, done;
    assign s = clean_note(note_code);
    assign blk_valid = full[drain_sel];
    assign blk_sel = drain_sel;
    // an accepted ack frees its buffer before this cycle's write looks at it
    assign clr = (blk_ack && blk_valid) ? (drain_sel ? 2'b10 : 2'b01) : 2'b00;
    assign full_c = full & ~clr;
    assign tgt = (state == IDLE) ? full_c[0] : fill_sel;
`ifdef NOTE_RLE_EN
    logic [3:0] run_note, run_len;
    logic sample, brk;
    assign sample = rec_en && state != FLUSH;
    assign brk = run_len != 4'd0 && (s != run_note || run_len == 4'd15);
    assign sample_emit = (state == FILL && !rec_en) ? run_len != 4'd0 : sample && brk;
    assign sample_byte = {run_len, run_note};
    always_ff @(posedge CLOCK_IO or negedge resetn)
        if (!resetn) begin
            run_note <= REST;
            run_len <= '0;
        end else if (sample) begin
            run_note <= s;
            run_len <= (brk || run_len == 4'd0) ? 4'd1 : run_len + 4'd1;
        end else if (state == FILL) begin
            run_len <= '0;
        end
`else
    assign sample_emit = rec_en && state != FLUSH;
    assign sample_byte = {4'h0, s};
`endif
    always_comb begin
        emit = state == FLUSH || sample_emit;
        wbyte = (state == FLUSH) ? (mark ? END_MARK : PAD) : sample_byte;
        blocked = emit && full_c[tgt];
        we = emit && !blocked;
        done = we && wr_ptr == LAST;
        state_n = (state == IDLE) ? (rec_en ? FILL : IDLE)
                : (state == FILL) ? (rec_en ? FILL : FLUSH)
                : (done ? IDLE : FLUSH);
    end
    always_ff @(posedge CLOCK_IO or negedge resetn)
        if (!resetn) state <= IDLE;
        else state <= state_n;
    always_ff @(posedge CLOCK_IO or negedge resetn)
        if (!resetn) begin
            wr_ptr <= '0;
            full <= '0;
            fill_sel <= 1'b0;
            drain_sel <= 1'b0;
            mark <= 1'b0;
            overrun <= 1'b0;
            blk_count <= '0;
        end else begin
            wr_ptr <= done ? 9'd0 : we ? wr_ptr + 9'd1 : wr_ptr;
            full <= full_c | (done ? (tgt ? 2'b10 : 2'b01) : 2'b00);
            fill_sel <= done ? ~tgt : tgt;
            drain_sel <= drain_sel ^ (|clr);
            mark <= (state == FILL && !rec_en) ? 1'b1 : we ? 1'b0 : mark;
            overrun <= overrun | blocked;
            blk_count <= blk_count + CNT_W'(done);
        end
    note_rec_dpram #(.DEPTH(DEPTH)) u_ram (
        .CLOCK_IO(CLOCK_IO),
        .resetn  (resetn),
        .we      (we),
        .waddr   ({tgt, wr_ptr[PW-1:0]}),
        .wdata   (wbyte),
        .raddr   ({drain_sel, rd_addr[PW-1:0]}),
        .rdata   (rd_data)
    );
endmodule

// File: tb/tb_note_record_pingpong.sv
// tb_note_record_pingpong: directed and random stimulus checked against a behavioural buffer model.
module tb_note_record_pingpong;
    localparam int D = 512;
    logic CLOCK_IO = 1'b0;
    logic resetn = 1'b0;
    logic rec_en = 1'b0;
    logic [3:0] note_code = 4'd0;
    logic blk_ack = 1'b0;
    logic [8:0] rd_addr = 9'd0;
    logic blk_valid, blk_sel, overrun;
    logic [7:0] rd_data;
    logic [8:0] wr_ptr;
    logic [15:0] blk_count;
    int n_tests = 0;
    int n_fail = 0;
    int m_st, m_ptr, m_fill, m_drain, m_cnt, run_note, run_len, exp_rd;
    bit m_ovr, m_mark;
    bit m_full[2];
    int mem[2][D];
    logic r;
    int nt;

    note_record_pingpong dut (
        .CLOCK_IO(CLOCK_IO), .resetn(resetn), .rec_en(rec_en), .note_code(note_code),
        .blk_valid(blk_valid), .blk_sel(blk_sel), .blk_ack(blk_ack), .rd_addr(rd_addr),
        .rd_data(rd_data), .overrun(overrun), .wr_ptr(wr_ptr), .blk_count(blk_count)
    );

    always #5 CLOCK_IO = ~CLOCK_IO;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_ptr = 0; m_fill = 0; m_drain = 0; m_cnt = 0;
        m_ovr = 0; m_mark = 0; m_full[0] = 0; m_full[1] = 0;
        run_note = 0; run_len = 0; exp_rd = -1;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < D; i++) mem[b][i] = -1;
    endtask

    // one clock of the recorder: ack first, then at most one byte into the fill buffer
    task automatic model_step(input bit rr, input int n, input bit a, input int ra);
        int s, b, tgt;
        bit emit, fin;
        s = (n > 12) ? 0 : n;
        emit = 0; b = 0; fin = 0;
        exp_rd = mem[m_drain][ra];
        if (a && m_full[m_drain]) begin
            m_full[m_drain] = 0;
            m_drain ^= 1;
        end
        tgt = (m_st == 0) ? (m_full[0] ? 1 : 0) : m_fill;
        if (m_st == 2) begin
            emit = 1;
            b = m_mark ? 255 : 0;
        end
`ifdef NOTE_RLE_EN
        else if (rr) begin
            if (run_len > 0 && (s != run_note || run_len == 15)) begin
                emit = 1; b = run_len * 16 + run_note; run_len = 0;
            end
            if (run_len == 0) begin run_note = s; run_len = 1; end
            else run_len++;
        end else if (m_st == 1 && run_len > 0) begin
            emit = 1; b = run_len * 16 + run_note; run_len = 0;
        end
`else
        else if (rr) begin
            emit = 1; b = s;
        end
`endif
        if (emit) begin
            if (m_full[tgt]) m_ovr = 1;
            else begin
                mem[tgt][m_ptr] = b;
                if (m_st == 2) m_mark = 0;
                if (m_ptr == D - 1) begin
                    m_full[tgt] = 1; m_cnt++; m_ptr = 0; tgt ^= 1; fin = (m_st == 2);
                end else m_ptr++;
            end
        end
        m_fill = tgt;
        if (m_st == 0 && rr) m_st = 1;
        else if (m_st == 1 && !rr) begin m_st = 2; m_mark = 1; end
        else if (m_st == 2 && fin) m_st = 0;
    endtask

    task automatic check_all();
        chk("blk_valid", 32'(blk_valid), 32'(m_full[m_drain]));
        chk("blk_sel", 32'(blk_sel), 32'(m_drain));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("wr_ptr", 32'(wr_ptr), 32'(m_ptr));
        chk("blk_count", 32'(blk_count), 32'(m_cnt & 16'hFFFF));
        if (exp_rd >= 0) chk("rd_data", 32'(rd_data), 32'(exp_rd));
    endtask

    task automatic cyc(input logic rr, input int n, input logic a, input int ra);
        rec_en = rr; note_code = 4'(n); blk_ack = a; rd_addr = 9'(ra);
        @(posedge CLOCK_IO);
        model_step(rr, n, a, ra);
        #1;
        check_all();
        blk_ack = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        resetn = 1'b0;
        #1;
        model_reset();
        chk({tag, "_valid"}, 32'(blk_valid), 0);
        chk({tag, "_sel"}, 32'(blk_sel), 0);
        chk({tag, "_rd"}, 32'(rd_data), 0);
        chk({tag, "_ovr"}, 32'(overrun), 0);
        chk({tag, "_ptr"}, 32'(wr_ptr), 0);
        chk({tag, "_cnt"}, 32'(blk_count), 0);
        #2 resetn = 1'b1;
    endtask

    initial begin
        do_reset("rst0");
        // steady note 5 fills buffer 0, then buffer 1 while buffer 0 is read out
        for (int i = 0; i < D; i++) cyc(1, 5, 0, 0);
        chk("b0_valid", 32'(blk_valid), 1);
        chk("b0_sel", 32'(blk_sel), 0);
        chk("b0_cnt", 32'(blk_count), 1);
        for (int i = 0; i < D; i++) begin
            cyc(1, 5, 0, i);
            chk("b0_byte", 32'(rd_data), 32'h05);
        end
        chk("b1_cnt", 32'(blk_count), 2);
        chk("b1_ovr_before", 32'(overrun), 0);
        cyc(1, 5, 0, 0);
        chk("ovr_set", 32'(overrun), 1);
        chk("ovr_ptr", 32'(wr_ptr), 0);
        cyc(1, 7, 0, 0);
        chk("ovr_sticky", 32'(overrun), 1);

        // ack lands on the same edge buffer 1 completes
        do_reset("rst1");
        for (int i = 0; i < 2 * D - 1; i++) cyc(1, 4, 0, 0);
        cyc(1, 4, 1, 0);
        chk("ack_ovr", 32'(overrun), 0);
        chk("ack_sel", 32'(blk_sel), 1);
        chk("ack_valid", 32'(blk_valid), 1);
        cyc(1, 4, 0, 0);
        chk("ack_ovr2", 32'(overrun), 0);
        chk("ack_ptr", 32'(wr_ptr), 1);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        chk("ack_ignored", 32'(blk_sel), 0);

        // short take, then flush pads the buffer
        do_reset("rst2");
`ifdef NOTE_RLE_EN
        for (int i = 0; i < 20; i++) cyc(1, 3, 0, 0);
        cyc(1, 7, 0, 0);
`else
        for (int i = 0; i < 3; i++) cyc(1, 2, 0, 0);
`endif
        for (int i = 0; i < D + 4; i++) cyc(0, 0, 0, 0);
        chk("flush_valid", 32'(blk_valid), 1);
        chk("flush_ptr", 32'(wr_ptr), 0);
        chk("flush_cnt", 32'(blk_count), 1);
        for (int i = 0; i < D; i++) begin
            cyc(0, 0, 0, i);
`ifdef NOTE_RLE_EN
            chk("rle_byte", 32'(rd_data), (i == 0) ? 32'hF3 : (i == 1) ? 32'h53 : (i == 2) ? 32'h17 : (i == 3) ? 32'hFF : 32'h00);
`else
            chk("flush_byte", 32'(rd_data), (i < 3) ? 32'h02 : (i == 3) ? 32'hFF : 32'h00);
`endif
        end
        cyc(1, 13, 0, 0);
        chk("restart_sel", 32'(wr_ptr), 32'(m_ptr));

        // random traffic with occasional stops, out-of-range notes and drains
        do_reset("rst3");
        r = 1'b1;
        nt = 1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 2) r = ~r;
            if ($urandom_range(0, 5) == 0) nt = $urandom_range(0, 15);
            cyc(r, nt, (m_full[m_drain] && $urandom_range(0, 39) == 0) || $urandom_range(0, 199) == 0,
                $urandom_range(0, D - 1));
        end

        // reset mid-fill discards the partial buffer
        do_reset("rst4");
        for (int i = 0; i < 100; i++) cyc(1, 9, 0, 0);
        chk("mid_ptr", 32'(wr_ptr), 100);
        do_reset("rst_mid");
        cyc(1, 9, 0, 0);
        chk("mid_restart_ptr", 32'(wr_ptr), 1);
        for (int i = 0; i < D - 1; i++) cyc(1, 9, 0, 0);
        chk("mid_restart_valid", 32'(blk_valid), 1);
        chk("mid_restart_sel", 32'(blk_sel), 0);
        chk("mid_restart_cnt", 32'(blk_count), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/note_record_pingpong.md
NOTE_RECORD_PINGPONG -- requirements
Module: note_record_pingpong

Interface
REQ-001 SHALL have parameter DEPTH, default 512, meaning bytes per buffer, which equals one SD sector.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of blk_count.
REQ-003 SHALL have port CLOCK_IO, input, 1 bit: note sample clock; all logic on its rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port rec_en, input, 1 bit: record mode, level.
REQ-006 SHALL have port note_code, input, 4 bits: 0 = rest, 1..12 = C..B.
REQ-007 SHALL have port blk_valid, output, 1 bit: a full buffer awaits drain.
REQ-008 SHALL have port blk_sel, output, 1 bit: index of the buffer offered.
REQ-009 SHALL have port blk_ack, input, 1 bit: one-cycle pulse meaning the drain is complete.
REQ-010 SHALL have port rd_addr, input, 9 bits: drain-side byte address within the blk_sel buffer.
REQ-011 SHALL have port rd_data, output, 8 bits: registered read data.
REQ-012 SHALL have port overrun, output, 1 bit: sticky flag, sample(s) dropped.
REQ-013 SHALL have port wr_ptr, output, 9 bits: next write index in the fill buffer.
REQ-014 SHALL have port blk_count, output, CNT_W bits: buffers completed, wraps modulo 2^CNT_W.

Function
REQ-015 SHALL implement states IDLE, FILL, FLUSH.
REQ-016 IDLE->FILL on rec_en=1; fill buffer = the non-full buffer, buffer 0 if both are free; wr_ptr=0.
REQ-017 FILL, one byte per cycle: note_code>12 SHALL be written as 0x00; the byte goes at wr_ptr, then wr_ptr+1.
REQ-018 On the write at wr_ptr=DEPTH-1: set full[fill], blk_count+1, wr_ptr->0, fill toggles.
REQ-019 If the target buffer is still full when writing: no RAM write, wr_ptr holds, overrun<=1 (sticky until reset).
REQ-020 FILL->FLUSH on rec_en=0; FLUSH writes 0xFF (end mark) at wr_ptr, then 0x00 each cycle to DEPTH-1, then sets full and goes to IDLE.
REQ-021 If rec_en returns to 1 during FLUSH, the flush SHALL complete before FILL is entered.
REQ-022 blk_valid = full[drain_sel]; blk_sel = drain_sel; drain_sel starts at 0.
REQ-023 blk_ack with blk_valid=1: full[drain_sel]<=0, drain_sel toggles; blk_ack with blk_valid=0: ignored.
REQ-024 On the same-cycle ack and buffer completion, the clear SHALL be applied before the overrun check, so there is no overrun when the freed buffer is the target.
REQ-025 rd_data = buffer[blk_sel][rd_addr], latency 1 cycle; rd_addr does not affect writes.

Reset
REQ-026 resetn=0 SHALL force: state=IDLE, wr_ptr=0, full=2'b00, drain_sel=0, blk_valid=0, blk_sel=0, rd_data=0, overrun=0, blk_count=0.
REQ-027 RAM contents SHALL be undefined after reset.
REQ-028 A reset mid-FILL or mid-FLUSH SHALL discard the partial buffer.

Configuration
REQ-029 NOTE_RLE_EN defined: each byte is {run[3:0], note[3:0]}.
  - run counts consecutive identical samples, 1..15.
  - The byte is emitted on a note change, on run=15, or on entry to FLUSH (pending run written before 0xFF).
  - Cycles that emit nothing SHALL NOT advance wr_ptr.
REQ-030 NOTE_RLE_EN undefined: raw mode per REQ-017, with RLE logic absent.

Structure
REQ-031 Package note_rec_pkg SHALL hold:
  - note code constants, REST=0 .. NOTE_B=12;
  - END_MARK=8'hFF and PAD=8'h00;
  - DEPTH default;
  - the state enum.
REQ-032 Sub-module note_rec_dpram: 2*DEPTH x 8, one write port and one registered read port; address MSB = buffer index.

Verification
REQ-033 rec_en=1, note_code=5 constant for 512 cycles -> blk_valid=1, blk_sel=0, blk_count=1, and a read of addr 0..511 returns 0x05.
REQ-034 Continue 512 more cycles with no ack -> buffer 1 full; the next sample sets overrun=1 and wr_ptr holds 0.
REQ-035 Pulse blk_ack in the same cycle as the second buffer completes -> overrun stays 0, blk_sel=1 next cycle.
REQ-036 Record 3 samples of 2, drop rec_en -> after flush, buffer holds 02,02,02,FF then 00 to index 511; state IDLE.
REQ-037 NOTE_RLE_EN: 20 samples of 3, then 1 of 7, then rec_en=0 -> bytes F3,53,17,FF, then 00 padding.
REQ-038 resetn low mid-FILL at wr_ptr=100 -> all outputs at reset values the same cycle; the next record starts at buffer 0, wr_ptr 0.
